approx_mult_scheduler: RTL and testbench

//  Round-robin scheduler sharing one pipelined approximate multiplier between NREQ DNN MAC lanes.
//  The multiplier is a PP generator + accumulate_pp tree + final adder.
//  - Arbitrates requests and issues one operand pair per cycle.
//  - Tracks in-flight products by tag.
//  - Returns each product to its owner through a one-entry response buffer with valid/ready.

---
 rtl/approx_mult_scheduler.sv | 157 +++++++++++++++
 tb/tb_approx_mult_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_scheduler.sv
// Round-robin scheduler sharing one pipelined multiplier between NREQ MAC lanes.
// Each lane owns a three-state FSM (IDLE/FLIGHT/HOLD) and a one-entry product
// buffer. The top level arbitrates, registers the operands to the multiplier and
// carries a {valid,id} tag alongside the datapath so that each product lands in
// its owner's buffer.

module approx_mult_lane #(
  parameter int BITWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  grant,
  input  logic                  capture,
  input  logic                  consume,
  input  logic [2*BITWIDTH-1:0] mult_p,
  output logic                  idle,
  output logic                  rsp_valid,
  output logic [2*BITWIDTH-1:0] rsp_p
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLIGHT = 2'd1, HOLD = 2'd2} state_t;
  state_t state;

  // Lane FSM: one outstanding product at a time, buffer kept until consumed.
  // A consume in HOLD returns to IDLE only, so a same-cycle request waits a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
    end else begin
      case (state)
        IDLE:   if (grant) state <= FLIGHT;
        FLIGHT: if (capture) begin
                  state     <= HOLD;
                  rsp_valid <= 1'b1;
                  rsp_p     <= mult_p;
                end
        HOLD:   if (consume) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                end
        default: begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                end
      endcase
    end
  end

  assign idle = (state == IDLE);

endmodule

module approx_mult_scheduler #(
  parameter int BITWIDTH = 8,
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][BITWIDTH-1:0]    req_a,
  input  logic [NREQ-1:0][BITWIDTH-1:0]    req_b,
  output logic [NREQ-1:0]                  rsp_valid,
  input  logic [NREQ-1:0]                  rsp_ready,
  output logic [NREQ-1:0][2*BITWIDTH-1:0]  rsp_p,
  output logic                             mult_valid,
  output logic [BITWIDTH-1:0]              mult_a,
  output logic [BITWIDTH-1:0]              mult_b,
  input  logic [2*BITWIDTH-1:0]            mult_p,
  output logic                             busy
);

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]             idle;
  logic [NREQ-1:0]             elig;
  logic [NREQ-1:0]             gnt_oh;
  logic                        gnt_any;
  logic [IDW-1:0]              gnt_id;
  logic [IDW-1:0]              rr_ptr;

  // Stage 0 is the operand register itself (mult_valid); stage MULT_LAT lines
  // up with a valid mult_p.
  logic [MULT_LAT:0]           vld_pipe;
  logic [MULT_LAT:0][IDW-1:0]  id_pipe;

  assign elig = req_valid & idle;

  // First eligible requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_v;
    gnt_any = 1'b0;
    gnt_id  = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_v = IDW'(idx);
      if (!gnt_any && elig[idx_v]) begin
        gnt_any = 1'b1;
        gnt_id  = idx_v;
      end
    end
    gnt_oh[gnt_id] = gnt_any;
  end

  // Gate with rst_n so no grant is advertised while the lanes are held in reset.
  assign req_ready = rst_n ? gnt_oh : '0;

  // Pointer moves past the winner; it holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (gnt_any)
      rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
  end

  // Operand issue and tag pipe; operands hold when there is no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      mult_a   <= '0;
      mult_b   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[MULT_LAT-1:0], gnt_any};
      id_pipe  <= {id_pipe[MULT_LAT-1:0], gnt_id};
      if (gnt_any) begin
        mult_a <= req_a[gnt_id];
        mult_b <= req_b[gnt_id];
      end
    end
  end

  assign mult_valid = vld_pipe[0];

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    approx_mult_lane #(.BITWIDTH(BITWIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .grant     (gnt_oh[g]),
      .capture   (vld_pipe[MULT_LAT] && (id_pipe[MULT_LAT] == IDW'(g))),
      .consume   (rsp_ready[g]),
      .mult_p    (mult_p),
      .idle      (idle[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_p     (rsp_p[g])
    );
  end

  assign busy = ~&idle;

endmodule

// File: tb/tb_approx_mult_scheduler.sv
// Directed bench for approx_mult_scheduler with an exact 2-stage multiplier model.
module tb_approx_mult_scheduler;
  localparam int BW = 8, NR = 4, ML = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR-1:0][BW-1:0]  req_a, req_b;
  logic [NR-1:0][2*BW-1:0] rsp_p;
  logic                   mult_valid, busy;
  logic [BW-1:0]          mult_a, mult_b;
  logic [2*BW-1:0]        mult_p, p1;
  int                     n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  // Exact multiplier, product valid MULT_LAT=2 edges after the operand edge.
  always_ff @(posedge clk) begin
    p1     <= {8'b0, mult_a} * {8'b0, mult_b};
    mult_p <= p1;
  end

  approx_mult_scheduler #(.BITWIDTH(BW), .NREQ(NR), .MULT_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .mult_valid(mult_valid), .mult_a(mult_a), .mult_b(mult_b),
    .mult_p(mult_p), .busy(busy)
  );

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
    n_tests++; if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid); end
    n_tests++; if (mult_valid !== 1'b0 || mult_a !== 8'd0 || mult_b !== 8'd0) begin
      n_fail++; $display("FAIL reset_mult: got v=%b a=%0d b=%0d exp 0/0/0", mult_valid, mult_a, mult_b); end
    n_tests++; if (rsp_p !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_p_busy: got p=%h busy=%b exp 0/0", rsp_p, busy); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk); req_valid = 4'b0001; req_a[0] = 8'd200; req_b[0] = 8'd150; #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b exp 0001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_tests++; if (mult_valid !== 1'b1 || mult_a !== 8'd200 || mult_b !== 8'd150) begin
      n_fail++; $display("FAIL single_issue: got v=%b a=%0d b=%0d exp 1/200/150", mult_valid, mult_a, mult_b); end
    @(negedge clk); #1;
    n_tests++; if (mult_valid !== 1'b0 || rsp_valid !== 4'b0) begin
      n_fail++; $display("FAIL single_t2: got mv=%b rsp=%b exp 0/0000", mult_valid, rsp_valid); end
    @(negedge clk); #1;
    n_tests++; if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL single_early: got %b exp 0000", rsp_valid); end
    @(negedge clk); #1;
    n_tests++; if (rsp_valid !== 4'b0001 || rsp_p[0] !== 16'd30000) begin
      n_fail++; $display("FAIL single_rsp: got v=%b p=%0d exp 0001/30000", rsp_valid, rsp_p[0]); end
    rsp_ready = 4'b0001;
    @(negedge clk); rsp_ready = '0; #1;
    n_tests++; if (rsp_valid !== 4'b0 || rsp_p[0] !== 16'd30000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_consume: got v=%b p=%0d busy=%b exp 0000/30000/0", rsp_valid, rsp_p[0], busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic       exp_mv  [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] exp_rsp [11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010,
                                 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    logic [15:0] prod;
    do_reset();
    for (int i = 0; i < NR; i++) begin req_a[i] = 8'(10 + i); req_b[i] = 8'(20 + i); end
    rsp_ready = 4'hF;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk); req_valid = (c <= 5) ? 4'hF : 4'h0; #1;
      n_tests++; if (req_ready !== exp_rdy[c] || mult_valid !== exp_mv[c] || rsp_valid !== exp_rsp[c]) begin
        n_fail++; $display("FAIL rr_cycle%0d: got rdy=%b mv=%b rsp=%b exp %b/%b/%b",
                           c, req_ready, mult_valid, rsp_valid, exp_rdy[c], exp_mv[c], exp_rsp[c]); end
      for (int i = 0; i < NR; i++) begin
        if (exp_rsp[c][i]) begin
          prod = 16'((10 + i) * (20 + i));
          n_tests++; if (rsp_p[i] !== prod) begin
            n_fail++; $display("FAIL rr_prod%0d: got %0d exp %0d", i, rsp_p[i], prod); end
        end
      end
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: busy got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    int ngr = 0;
    req_a[1] = 8'd255; req_b[1] = 8'd255;
    for (int d = 0; d < 14; d++) begin
      @(negedge clk); req_valid = 4'b0111; rsp_ready = 4'b1101; #1;
      if (d == 0) begin
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %b exp 0010", req_ready); end
      end else begin
        n_tests++; if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_no_regrant d%0d: got %b exp 0", d, req_ready[1]); end
        if (req_ready[0] || req_ready[2]) ngr++;
      end
      if (d >= 4) begin
        n_tests++; if (rsp_valid[1] !== 1'b1 || rsp_p[1] !== 16'd65025) begin
          n_fail++; $display("FAIL bp_hold d%0d: got v=%b p=%0d exp 1/65025", d, rsp_valid[1], rsp_p[1]); end
      end
    end
    n_tests++; if (ngr != 6) begin n_fail++; $display("FAIL bp_other_grants: got %0d exp 6", ngr); end
    @(negedge clk); req_valid = '0; rsp_ready = 4'hF;
    repeat (6) @(negedge clk);
    #1;
    n_tests++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: got rsp=%b busy=%b exp 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_consume_request();
    req_a[2] = 8'd12; req_b[2] = 8'd34; rsp_ready = '0;
    @(negedge clk); req_valid = 4'b0100; #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL cr_grant: got %b exp 0100", req_ready); end
    for (int e = 1; e < 4; e++) begin
      @(negedge clk); #1;
      n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL cr_flight e%0d: got %b exp 0000", e, req_ready); end
    end
    @(negedge clk); rsp_ready = 4'b0100; #1;
    n_tests++; if (req_ready !== 4'b0 || rsp_valid !== 4'b0100 || rsp_p[2] !== 16'd408) begin
      n_fail++; $display("FAIL cr_same_cycle: got rdy=%b rsp=%b p=%0d exp 0000/0100/408", req_ready, rsp_valid, rsp_p[2]); end
    @(negedge clk); #1;
    n_tests++; if (req_ready !== 4'b0100 || rsp_valid !== 4'b0) begin
      n_fail++; $display("FAIL cr_next_cycle: got rdy=%b rsp=%b exp 0100/0000", req_ready, rsp_valid); end
    @(negedge clk); req_valid = '0; rsp_ready = 4'hF;
    repeat (5) @(negedge clk);
    #1;
    n_tests++; if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL cr_drain: got %b exp 0000", rsp_valid); end
  endtask

  task automatic test_pointer_fairness();
    logic [3:0] exp_rdy [8] = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0010};
    logic [3:0] exp_rsp [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1010, 4'b0000, 4'b0000};
    req_a[3] = 8'd7;  req_b[3] = 8'd9;
    req_a[1] = 8'd11; req_b[1] = 8'd13;
    rsp_ready = '0;
    for (int f = 0; f < 8; f++) begin
      @(negedge clk); req_valid = 4'b1010; if (f >= 5) rsp_ready = 4'hF; #1;
      n_tests++; if (req_ready !== exp_rdy[f] || rsp_valid !== exp_rsp[f]) begin
        n_fail++; $display("FAIL rr_ptr f%0d: got rdy=%b rsp=%b exp %b/%b", f, req_ready, rsp_valid, exp_rdy[f], exp_rsp[f]); end
      if (f == 5) begin
        n_tests++; if (rsp_p[3] !== 16'd63 || rsp_p[1] !== 16'd143) begin
          n_fail++; $display("FAIL rr_ptr_prod: got p3=%0d p1=%0d exp 63/143", rsp_p[3], rsp_p[1]); end
      end
    end
    @(negedge clk); req_valid = '0;
    repeat (6) @(negedge clk);
    #1;
    n_tests++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rr_ptr_drain: got rsp=%b busy=%b exp 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_reset_midflight();
    req_a[0] = 8'd3; req_b[0] = 8'd5; req_a[1] = 8'd4; req_b[1] = 8'd6; rsp_ready = '0;
    @(negedge clk); req_valid = 4'b0011; #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mr_grant0: got %b exp 0001", req_ready); end
    @(negedge clk); #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mr_grant1: got %b exp 0010", req_ready); end
    @(negedge clk); req_valid = '0; rst_n = 1'b0; #1;
    n_tests++; if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || mult_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mr_outputs: got rdy=%b rsp=%b mv=%b busy=%b exp all 0", req_ready, rsp_valid, mult_valid, busy); end
    n_tests++; if (mult_a !== 8'd0 || mult_b !== 8'd0 || rsp_p !== '0) begin
      n_fail++; $display("FAIL mr_data: got a=%0d b=%0d p=%h exp 0", mult_a, mult_b, rsp_p); end
    @(negedge clk); rst_n = 1'b1;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk); #1;
      n_tests++; if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL mr_late g%0d: got %b exp 0000", g, rsp_valid); end
    end
    @(negedge clk); req_valid = 4'b0101; #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mr_regrant: got %b exp 0001", req_ready); end
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (rsp_valid !== 4'b0001 || rsp_p[0] !== 16'd15) begin
      n_fail++; $display("FAIL mr_result: got v=%b p=%0d exp 0001/15", rsp_valid, rsp_p[0]); end
    rsp_ready = 4'hF;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_consume_request();
    test_pointer_fairness();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
